// File: rtl/dsp_pkg.sv
// Shared DSP definitions: channel/word constants, sample type, instruction fields, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_pkg;

   // Core datapath geometry.
   localparam int DSP_N_CH   = 8;
   localparam int DSP_WORD_W = 36;

   typedef logic [DSP_WORD_W-1:0] sample_t;

   // Instruction word fields. The core decodes these. A later revision of the
   // sequencer derives its program length from the loaded program using them.
   localparam int OP_MSB = 35;
   localparam int OP_LSB = 30;
   localparam int RW_MSB = 29;
   localparam int RW_LSB = 20;
   localparam int RA_MSB = 19;
   localparam int RA_LSB = 10;
   localparam int RB_MSB = 9;
   localparam int RB_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_RUN     = 2'd2,
      S_CAPTURE = 2'd3
   } seq_state_t;

   // Cycles spent in RUN per frame: program issue plus pipeline drain.
   function automatic int frame_len(input int prog_len, input int pipe_lat);
      return prog_len + pipe_lat;
   endfunction

   // Field extractors for instruction words.
   function automatic logic [OP_MSB-OP_LSB:0] instr_op(input sample_t w);
      return w[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [RW_MSB-RW_LSB:0] instr_rw(input sample_t w);
      return w[RW_MSB:RW_LSB];
   endfunction

   function automatic logic [RA_MSB-RA_LSB:0] instr_ra(input sample_t w);
      return w[RA_MSB:RA_LSB];
   endfunction

   function automatic logic [RB_MSB-RB_LSB:0] instr_rb(input sample_t w);
      return w[RB_MSB:RB_LSB];
   endfunction

endpackage

// File: rtl/dsp_frame_sequencer_if.sv
// Bundle between the frame sequencer, the ADC/DAC side and the DSP core.
// Latency: n/a (wires only).
// Backpressure: none. Ticks are strobes; out_valid is a one-cycle strobe with no ready.
// Signals:
//   enable, sample_tick, in_samples  : tick gating, tick strobe, ADC samples
//   core_start, core_inputs          : start pulse and latched samples to the core
//   core_outputs                     : core result registers
//   out_samples, out_valid           : captured results and their strobe
//   busy, overrun, overrun_clr       : status, sticky overrun flag and its clear
//   frame_count                      : completed-frame counter
interface dsp_frame_sequencer_if
   import dsp_pkg::*;
#(
   parameter int N_CH   = DSP_N_CH,
   parameter int WORD_W = DSP_WORD_W,
   parameter int CNT_W  = 16
);

   logic                           enable;
   logic                           sample_tick;
   logic [N_CH-1:0][WORD_W-1:0]    in_samples;
   logic                           core_start;
   logic [N_CH-1:0][WORD_W-1:0]    core_inputs;
   logic [N_CH-1:0][WORD_W-1:0]    core_outputs;
   logic [N_CH-1:0][WORD_W-1:0]    out_samples;
   logic                           out_valid;
   logic                           busy;
   logic                           overrun;
   logic                           overrun_clr;
   logic [CNT_W-1:0]               frame_count;

   // Sequencer side.
   modport slave (
      input  enable,
      input  sample_tick,
      input  in_samples,
      input  core_outputs,
      input  overrun_clr,
      output core_start,
      output core_inputs,
      output out_samples,
      output out_valid,
      output busy,
      output overrun,
      output frame_count
   );

   // Environment side: ADC, core and host.
   modport master (
      output enable,
      output sample_tick,
      output in_samples,
      output core_outputs,
      output overrun_clr,
      input  core_start,
      input  core_inputs,
      input  out_samples,
      input  out_valid,
      input  busy,
      input  overrun,
      input  frame_count
   );

endinterface

// File: rtl/frame_timer.sv
// Loadable down-counter with zero flag; times the RUN phase of a frame.
// Latency: load takes effect next cycle; zero flag is combinational from the count.
// Backpressure: none. Decrement requests at zero are ignored (count saturates at 0).
// Ports: i_clk, i_reset_n, i_load/i_load_val (load count), i_dec (count down), o_zero.
module frame_timer #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_zero;

   assign w_zero = (r_cnt == '0);
   assign o_zero = w_zero;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && !w_zero) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dsp_frame_sequencer.sv
// Sample-rate scheduler: latches samples on a tick, pulses core start, waits the program
// length, then captures core results. Latency: tick in cycle T -> core_start in T+1,
// out_valid in T+L+3 (L = PROG_LEN+PIPE_LAT). Backpressure: none; ticks arriving while a
// frame is in LAUNCH/RUN are dropped and raise the sticky overrun flag.
// Ports: i_clk, i_reset_n (async active-low), io_seq (slave side of dsp_frame_sequencer_if).
module dsp_frame_sequencer
   import dsp_pkg::*;
#(
   parameter int N_CH     = DSP_N_CH,
   parameter int WORD_W   = DSP_WORD_W,
   parameter int PROG_LEN = 64,
   parameter int PIPE_LAT = 3,
   parameter int CNT_W    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   dsp_frame_sequencer_if.slave  io_seq
);

   localparam int L     = frame_len(PROG_LEN, PIPE_LAT);
   // The timer holds values L-1 down to 0.
   localparam int TMR_W = (L > 1) ? $clog2(L) : 1;

   if (L < 1) begin : g_bad_len
      $error("dsp_frame_sequencer: PROG_LEN + PIPE_LAT must be at least 1");
   end

   seq_state_t                    r_state;
   seq_state_t                    w_state_nxt;

   logic                          w_tick;
   logic                          w_timer_zero;
   logic                          w_start_nxt;
   logic                          w_latch_in;
   logic                          w_capture;
   logic                          w_ovr_set;
   logic                          w_tmr_load;
   logic                          w_tmr_dec;

   logic                          r_core_start;
   logic                          r_out_valid;
   logic                          r_overrun;
   logic [CNT_W-1:0]              r_frame_count;
   logic [N_CH-1:0][WORD_W-1:0]   r_core_inputs;
   logic [N_CH-1:0][WORD_W-1:0]   r_out_samples;

   // A tick only counts when enabled; enable has no other effect on a running frame.
   assign w_tick = io_seq.sample_tick & io_seq.enable;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_timer_zero) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            // A tick landing on CAPTURE chains straight into the next frame.
            w_state_nxt = w_tick ? S_LAUNCH : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- output decode
   always_comb begin
      // core_start is registered, so it is decoded from the state being entered.
      w_start_nxt = (w_state_nxt == S_LAUNCH);
      w_latch_in  = w_tick && ((r_state == S_IDLE) || (r_state == S_CAPTURE));
      w_capture   = (r_state == S_CAPTURE);
      w_ovr_set   = w_tick && ((r_state == S_LAUNCH) || (r_state == S_RUN));
      w_tmr_load  = (r_state == S_LAUNCH);
      w_tmr_dec   = (r_state == S_RUN);
   end

   // ---------------------------------------------------------------- RUN timer
   // Loaded with L-1 on leaving LAUNCH; RUN ends on the cycle it reads zero,
   // giving exactly L RUN cycles.
   frame_timer #(
      .CNT_W      (TMR_W)
   ) u_frame_timer (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (w_tmr_load),
      .i_dec      (w_tmr_dec),
      .i_load_val (TMR_W'(L - 1)),
      .o_zero     (w_timer_zero)
   );

   // ---------------------------------------------------------------- registered outputs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_core_start  <= 1'b0;
         r_out_valid   <= 1'b0;
         r_overrun     <= 1'b0;
         r_frame_count <= '0;
         r_core_inputs <= '0;
         r_out_samples <= '0;
      end else begin
         r_core_start <= w_start_nxt;
         r_out_valid  <= w_capture;

         // Held until the next accepted tick; dropped ticks never disturb it.
         if (w_latch_in) begin
            r_core_inputs <= io_seq.in_samples;
         end

         if (w_capture) begin
            r_out_samples <= io_seq.core_outputs;
            r_frame_count <= r_frame_count + CNT_W'(1);
         end

         // Set has priority so a clear cannot hide an overrun in the same cycle.
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (io_seq.overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign io_seq.core_start  = r_core_start;
   assign io_seq.core_inputs = r_core_inputs;
   assign io_seq.out_samples = r_out_samples;
   assign io_seq.out_valid   = r_out_valid;
   assign io_seq.busy        = (r_state != S_IDLE);
   assign io_seq.overrun     = r_overrun;
   assign io_seq.frame_count = r_frame_count;

endmodule
